// File: rtl/bus_term_pkg.sv
// Shared widths, the broadcast address and helpers for the bus terminal FIFO.
package bus_term_pkg;
  localparam int ID_W    = 8;
  localparam int CNT_W   = 16;
  localparam int PKT_MAX = 64;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Callers zero-extend the packet to PKT_MAX and pass its real width.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt,
                                               input int pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == '1) ? val : val + CNT_W'(1);
  endfunction
endpackage

// File: rtl/term_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write into a full FIFO is taken
// when a read retires the head in the same cycle.
module term_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_ok   = rd & ~empty;
  assign wr_ok   = wr & (~full | rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/bus_terminal_fifo.sv
// Bus-side terminal: TX FIFO popped by the bus, RX FIFO filled by the bus,
// plus destination checking and saturating error counters.
module bus_terminal_fifo
  import bus_term_pkg::*;
#(
  parameter int              PCKG_SZ = 16,
  parameter int              DEPTH   = 8,
  parameter logic [ID_W-1:0] ID      = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       pndng,
  output logic [PCKG_SZ-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [PCKG_SZ-1:0]         D_push,
  input  logic                       wr_en,
  input  logic [PCKG_SZ-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(DEPTH+1)-1:0] tx_count,
  input  logic                       rd_en,
  output logic [PCKG_SZ-1:0]         rd_data,
  output logic                       rx_valid,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic [CNT_W-1:0]           tx_drop_cnt,
  output logic [CNT_W-1:0]           rx_ovf_cnt,
  output logic [CNT_W-1:0]           misroute_cnt,
  output logic                       pop_underflow
);
  logic            tx_empty;
  logic            rx_empty;
  logic            rx_full;
  logic            tx_drop;
  logic            rx_ovf;
  logic            misroute;
  logic [ID_W-1:0] dest;

  term_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .wr(wr_en), .wr_data(wr_data), .rd(pop), .rd_data(D_pop),
    .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  term_sync_fifo #(.WIDTH(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .wr(push), .wr_data(D_push), .rd(rd_en), .rd_data(rd_data),
    .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign pndng    = ~tx_empty;
  assign rx_valid = ~rx_empty;

  // When full, the head is always valid, so a same-cycle pop/read frees a slot.
  assign tx_drop  = wr_en & tx_full & ~pop;
  assign rx_ovf   = push & rx_full & ~rd_en;
  assign dest     = get_dest(PKT_MAX'(D_push), PCKG_SZ);
  assign misroute = push & (dest != ID) & (dest != BROADCAST_ID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_drop_cnt   <= '0;
      rx_ovf_cnt    <= '0;
      misroute_cnt  <= '0;
      pop_underflow <= 1'b0;
    end else begin
      if (tx_drop)         tx_drop_cnt   <= sat_inc(tx_drop_cnt);
      if (rx_ovf)          rx_ovf_cnt    <= sat_inc(rx_ovf_cnt);
      if (misroute)        misroute_cnt  <= sat_inc(misroute_cnt);
      if (pop && tx_empty) pop_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Self-checking bench for bus_terminal_fifo (ID=3, 16-bit packets, depth 8).
module tb_bus_terminal_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx_full;
  logic [3:0]  tx_count;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rx_valid;
  logic [3:0]  rx_count;
  logic [15:0] tx_drop_cnt;
  logic [15:0] rx_ovf_cnt;
  logic [15:0] misroute_cnt;
  logic        pop_underflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];

  typedef struct {
    logic        wr;
    logic [15:0] wd;
    logic        pp;
    logic        ps;
    logic [15:0] dp;
    logic        rd;
    logic        wr_acc;
    logic        ps_acc;
    logic [3:0]  e_txc;
    logic [3:0]  e_rxc;
    logic [15:0] e_mis;
  } vec_t;

  vec_t vecs[12];

  bus_terminal_fifo #(.PCKG_SZ(16), .DEPTH(8), .ID(8'd3)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .rd_en(rd_en), .rd_data(rd_data),
    .rx_valid(rx_valid), .rx_count(rx_count), .tx_drop_cnt(tx_drop_cnt),
    .rx_ovf_cnt(rx_ovf_cnt), .misroute_cnt(misroute_cnt),
    .pop_underflow(pop_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus/host cycle; heads are scoreboarded before the edge that consumes them.
  task automatic op(input logic wr, input logic [15:0] wd, input logic pp,
                    input logic ps, input logic [15:0] dp, input logic rd,
                    input logic wr_acc, input logic ps_acc);
    wr_en = wr; wr_data = wd; pop = pp; push = ps; D_push = dp; rd_en = rd;
    if (pp) begin
      chk("pndng", {31'd0, pndng}, {31'd0, tx_q.size() != 0});
      if (tx_q.size() != 0) chk("d_pop", {16'd0, D_pop}, {16'd0, tx_q.pop_front()});
    end
    if (rd) begin
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, rx_q.size() != 0});
      if (rx_q.size() != 0) chk("rd_data", {16'd0, rd_data}, {16'd0, rx_q.pop_front()});
    end
    if (wr_acc) tx_q.push_back(wd);
    if (ps_acc) rx_q.push_back(dp);
    tick();
    wr_en = 0; pop = 0; push = 0; rd_en = 0;
  endtask

  initial begin
    //          wr  wd        pop ps  dp        rd  wacc pacc txc rxc mis
    vecs[0]  = '{1, 16'h0A11, 0, 0, 16'h0000, 0, 1, 0, 4'd1, 4'd0, 16'd0};
    vecs[1]  = '{1, 16'h0B22, 0, 0, 16'h0000, 0, 1, 0, 4'd2, 4'd0, 16'd0};
    vecs[2]  = '{1, 16'h0C33, 0, 0, 16'h0000, 0, 1, 0, 4'd3, 4'd0, 16'd0};
    vecs[3]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 4'd2, 4'd0, 16'd0};
    vecs[4]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 4'd1, 4'd0, 16'd0};
    vecs[5]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 4'd0, 4'd0, 16'd0};
    vecs[6]  = '{0, 16'h0000, 0, 1, 16'h03AA, 0, 0, 1, 4'd0, 4'd1, 16'd0};
    vecs[7]  = '{0, 16'h0000, 0, 1, 16'hFF55, 0, 0, 1, 4'd0, 4'd2, 16'd0};
    vecs[8]  = '{0, 16'h0000, 0, 1, 16'h0712, 0, 0, 1, 4'd0, 4'd3, 16'd1};
    vecs[9]  = '{0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 4'd0, 4'd2, 16'd1};
    vecs[10] = '{0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 4'd0, 4'd1, 16'd1};
    vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 4'd0, 4'd0, 16'd1};

    reset = 0; wr_en = 0; wr_data = 0; pop = 0; push = 0; D_push = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pndng", {31'd0, pndng}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
    chk("rst_underflow", {31'd0, pop_underflow}, 32'd0);
    chk("rst_d_pop", {16'd0, D_pop}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    reset = 1;

    foreach (vecs[i]) begin
      op(vecs[i].wr, vecs[i].wd, vecs[i].pp, vecs[i].ps, vecs[i].dp, vecs[i].rd,
         vecs[i].wr_acc, vecs[i].ps_acc);
      chk($sformatf("v%0d_tx_count", i), {28'd0, tx_count}, {28'd0, vecs[i].e_txc});
      chk($sformatf("v%0d_rx_count", i), {28'd0, rx_count}, {28'd0, vecs[i].e_rxc});
      chk($sformatf("v%0d_misroute", i), {16'd0, misroute_cnt}, {16'd0, vecs[i].e_mis});
    end
    chk("tx_drained_pndng", {31'd0, pndng}, 32'd0);

    // TX full, dropped write, then write accepted alongside a pop
    for (int i = 0; i < 8; i++) op(1, 16'h3000 + 16'(i), 0, 0, 0, 0, 1, 0);
    chk("fill_tx_full", {31'd0, tx_full}, 32'd1);
    op(1, 16'h30FF, 0, 0, 0, 0, 0, 0);
    chk("drop_cnt_1", {16'd0, tx_drop_cnt}, 32'd1);
    chk("drop_tx_count", {28'd0, tx_count}, 32'd8);
    op(1, 16'h30AA, 1, 0, 0, 0, 1, 0);
    chk("wr_pop_full_count", {28'd0, tx_count}, 32'd8);
    chk("wr_pop_full_drop", {16'd0, tx_drop_cnt}, 32'd1);
    for (int i = 0; i < 8; i++) op(0, 0, 1, 0, 0, 0, 0, 0);
    chk("tx_drain_count", {28'd0, tx_count}, 32'd0);
    chk("tx_drain_pndng", {31'd0, pndng}, 32'd0);
    chk("no_underflow_yet", {31'd0, pop_underflow}, 32'd0);

    // Underflow, then a write after it
    op(0, 0, 1, 0, 0, 0, 0, 0);
    chk("underflow_set", {31'd0, pop_underflow}, 32'd1);
    chk("underflow_count", {28'd0, tx_count}, 32'd0);
    op(1, 16'h1234, 0, 0, 0, 0, 1, 0);
    chk("post_uf_pndng", {31'd0, pndng}, 32'd1);
    chk("post_uf_d_pop", {16'd0, D_pop}, 32'h1234);
    op(0, 0, 1, 0, 0, 0, 0, 0);
    // Pop and write together on an empty FIFO: write lands
    op(1, 16'h4321, 1, 0, 0, 0, 1, 0);
    chk("pop_wr_empty_count", {28'd0, tx_count}, 32'd1);
    op(0, 0, 1, 0, 0, 0, 0, 0);

    // RX overflow with a misrouted dropped packet; pointers wrap
    for (int i = 0; i < 8; i++) op(0, 0, 0, 1, 16'h0300 + 16'(i), 0, 0, 1);
    op(0, 0, 0, 1, 16'h0708, 0, 0, 0);
    chk("rx_ovf_1", {16'd0, rx_ovf_cnt}, 32'd1);
    chk("rx_full_count", {28'd0, rx_count}, 32'd8);
    chk("misroute_dropped", {16'd0, misroute_cnt}, 32'd2);
    op(0, 0, 0, 1, 16'h03EE, 1, 0, 1);
    chk("push_rd_full_ovf", {16'd0, rx_ovf_cnt}, 32'd1);
    chk("push_rd_full_count", {28'd0, rx_count}, 32'd8);
    for (int i = 0; i < 8; i++) op(0, 0, 0, 0, 0, 1, 0, 0);
    op(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rd_empty_count", {28'd0, rx_count}, 32'd0);
    chk("rd_empty_ovf", {16'd0, rx_ovf_cnt}, 32'd1);
    chk("rd_empty_rd_data", {16'd0, rd_data}, 32'd0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) op(1, 16'h5000 + 16'(i), 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) op(0, 0, 0, 1, 16'h0360 + 16'(i), 0, 0, 1);
    chk("pre_rst_tx_count", {28'd0, tx_count}, 32'd5);
    chk("pre_rst_rx_count", {28'd0, rx_count}, 32'd3);
    #2;
    reset = 0;
    #1;
    chk("arst_pndng", {31'd0, pndng}, 32'd0);
    chk("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("arst_tx_count", {28'd0, tx_count}, 32'd0);
    chk("arst_rx_count", {28'd0, rx_count}, 32'd0);
    chk("arst_drop", {16'd0, tx_drop_cnt}, 32'd0);
    chk("arst_ovf", {16'd0, rx_ovf_cnt}, 32'd0);
    chk("arst_misroute", {16'd0, misroute_cnt}, 32'd0);
    chk("arst_underflow", {31'd0, pop_underflow}, 32'd0);
    tx_q.delete();
    rx_q.delete();
    tick();
    reset = 1;
    op(1, 16'h0ABC, 0, 1, 16'hFF01, 0, 1, 1);
    chk("rt_pndng", {31'd0, pndng}, 32'd1);
    chk("rt_rx_valid", {31'd0, rx_valid}, 32'd1);
    op(0, 0, 1, 0, 0, 1, 0, 0);
    chk("rt_tx_count", {28'd0, tx_count}, 32'd0);
    chk("rt_rx_count", {28'd0, rx_count}, 32'd0);
    chk("rt_misroute", {16'd0, misroute_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_terminal_fifo.md
Name: bus_terminal_fifo

Overview:
- Terminal-side endpoint of the bs_gnrtr_n_rbtr bus-driver protocol; one instance per driver port.
- Contains a TX FIFO: a host loads packets, and the bus pops them through pndng/pop/D_pop.
- Contains an RX FIFO: the bus pushes delivered packets through push/D_push, and the host drains them.
- Checks the destination of each received packet and keeps saturating error counters, so the bench and system can flag misrouting and overflow.

Parameters:
- PCKG_SZ, 16, packet width in bits; destination ID is bits [PCKG_SZ-1 -: 8].
- DEPTH, 8, entries per FIFO (power of two, >=2).
- ID, 0, this terminal's 8-bit address.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pndng  out  1  TX FIFO non-empty (to bus)
- D_pop  out  PCKG_SZ  TX FIFO head, first-word-fall-through
- pop  in  1  bus consumes TX head this cycle
- push  in  1  bus delivers packet this cycle
- D_push  in  PCKG_SZ  delivered packet
- wr_en  in  1  host write into TX FIFO
- wr_data  in  PCKG_SZ  host write data
- tx_full  out  1  TX FIFO full
- tx_count  out  $clog2(DEPTH+1)  TX occupancy
- rd_en  in  1  host read from RX FIFO
- rd_data  out  PCKG_SZ  RX FIFO head, first-word-fall-through
- rx_valid  out  1  RX FIFO non-empty
- rx_count  out  $clog2(DEPTH+1)  RX occupancy
- tx_drop_cnt  out  16  host writes dropped while full, saturating
- rx_ovf_cnt  out  16  bus pushes dropped while full, saturating
- misroute_cnt  out  16  received packets with wrong destination, saturating
- pop_underflow  out  1  sticky: pop seen while pndng=0

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all pointers and counts to 0;
  - pndng, rx_valid, tx_full and pop_underflow to 0;
  - all counters to 0.
- D_pop and rd_data read 0 while their FIFO is empty.
- Reset asserted mid-operation discards FIFO contents immediately. Deassertion is sampled synchronously; the first operation is accepted on the first rising edge with reset=1.
- All status outputs are registered or derived from registered state. There are no combinational paths from pop/push/wr_en/rd_en to any output.
- TX write: wr_en with tx_full=0 stores wr_data; it is visible on D_pop and pndng=1 one cycle later (latency 1).
- TX write when full: dropped and tx_drop_cnt increments. Exception: if pop=1 in the same cycle, the write is accepted and count is unchanged.
- TX pop: pop with pndng=1 advances the head; the next entry appears on D_pop the following cycle.
- Pop with pndng=0 is ignored, sets pop_underflow, and does not corrupt pointers.
- A pop and a write in the same cycle on an empty TX FIFO: the pop is an underflow and the write is stored.
- RX push: push with RX not full stores D_push, and rx_valid rises next cycle.
- RX push when full: dropped and rx_ovf_cnt increments. Exception: if rd_en=1 with rx_valid=1 in the same cycle, both succeed.
- rd_en with rx_valid=0 is ignored and produces no error.
- Destination check on every push, dropped or not:
  - dest = D_push[PCKG_SZ-1 -: 8];
  - if dest != ID and dest != 8'hFF (broadcast), misroute_cnt increments;
  - the packet is still stored if space exists.
- All counters saturate at 16'hFFFF and never wrap.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count distinguishes full from empty.
- tx_full = (tx_count == DEPTH).

Decomposition:
- Package bus_term_pkg holds:
  - ID_W=8;
  - BROADCAST_ID=8'hFF;
  - function get_dest(pkt) returning the top ID_W bits;
  - a saturating-increment function for the 16-bit counters.
- Sub-module term_sync_fifo (parameters WIDTH, DEPTH) implements:
  - wr/rd ports, first-word-fall-through head, count, full, empty;
  - accept-write-when-full-with-simultaneous-read.
- term_sync_fifo is instantiated twice (TX, RX). The top adds error counters, the destination check and underflow logic.

Test Plan:
- Reset, then write 0x0A11, 0x0B22, 0x0C33 via wr_en, then pop three times when pndng=1 -> D_pop shows 0x0A11, 0x0B22, 0x0C33 in order; pndng=0 afterwards; tx_count returns to 0.
- With ID=3, push 0x03AA, 0xFF55 and 0x0712 -> rx_count=3; rd_data order preserved; misroute_cnt=1 (only 0x0712).
- Fill TX with 8 writes, then a 9th write alone -> tx_drop_cnt=1. A 10th write together with pop -> accepted; tx_count stays 8; tx_drop_cnt stays 1.
- Pop on empty TX, then write 0x1234 -> pop_underflow=1; D_pop=0x1234 one cycle after the write; pndng=1.
- Push 9 packets into RX with no reads -> rx_ovf_cnt=1; the 9th packet is absent; the first 8 are read back intact, wrapping pointers once.
- Assert reset low mid-burst with TX=5 and RX=3 entries -> pndng, rx_valid and all counters are 0 immediately, without waiting for a clock edge. After release, a single write/push round-trips correctly.
